sequencer: RTL and testbench
============================

SEQUENCER -- requirements
Module: sequencer

Interface
REQ-001 Parameter STACK_DEPTH, default 4: number of micro-subroutine return entries, range 2..8.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 go  input  1  start/resume request, sampled each cycle.
REQ-005 opcode  input  4  instruction opcode from the instruction register.
REQ-006 bop  input  4  branch-operation field of the current microword.
REQ-007 count  input  1  microword COUNT bit: 1 = sequential, 0 = jump.
REQ-008 micro_ad_high  input  4  microword target address, high nibble.
REQ-009 micro_ad_low  input  4  microword target address, low nibble.
REQ-010 zero, carry, negative, overflow  input  1 each  ALU status flags, valid in the current cycle.
REQ-011 microaddress  output  8  registered address driven to the control store.
REQ-012 dispatch  output  1  high for the cycle in which an opcode dispatch is taken.
REQ-013 halted  output  1  high while in HALT.
REQ-014 stack_err  output  1  sticky stack overflow/underflow flag.

Function
REQ-015 The block SHALL implement the states IDLE, RUN and HALT; reset enters IDLE.
REQ-016 IDLE: hold microaddress at 8'h00; go=1 moves the state to RUN at the next edge with microaddress unchanged.
REQ-017 RUN: each edge SHALL load microaddress with the next address computed from the current microword fields (one-cycle latency; control store combinational).
REQ-018 TGT = {micro_ad_high, micro_ad_low}; INC = microaddress+1, wrapping 8'hFF to 8'h00.
REQ-019 bop 0000 CONT: next = count ? INC : TGT.
REQ-020 bop 0001 DISPATCH: next = {opcode, 4'h0}; dispatch=1 in that cycle.
REQ-021 bop 0010/0011 JZ/JNZ, 0100/0101 JC/JNC, 0110/0111 JN/JV: next = TGT if the condition holds, else INC.
REQ-022 bop 1000 CALL: push INC, next = TGT.
REQ-023 bop 1001 RET: pop; next = popped value.
REQ-024 bop 1010 HALT: next = INC, state moves to HALT; halted=1 from that edge.
REQ-025 bop 1011..1111 SHALL behave as CONT.
REQ-026 HALT: microaddress held; go=1 returns to RUN at the next edge, resuming at the held address.
REQ-027 go is ignored in RUN.
REQ-028 CALL with the stack full: the oldest entry is discarded, the push completes and stack_err is set.
REQ-029 RET with the stack empty: next = 8'h00 and stack_err is set.
REQ-030 dispatch SHALL be 0 outside RUN.
REQ-031 Flags SHALL be ignored for all non-conditional bop codes.

Reset
REQ-032 rst_n low SHALL immediately force state=IDLE, microaddress=8'h00, dispatch=0, halted=0, stack_err=0 and stack empty, including mid-CALL or mid-RET.
REQ-033 After rst_n rises, the first state change requires go=1.

Structure
REQ-034 BOP encodings and state encodings SHALL live in the shared microcode package/include, also used by the control store and assembler tables.
REQ-035 The return stack SHALL be a sub-module micro_stack with ports: push, pop, din[7:0], dout[7:0], full, empty, and parameter STACK_DEPTH.
REQ-036 Next-address selection SHALL be combinational; only state, microaddress, stack and stack_err are registered.

Verification
REQ-037 Reset, go=1, bop=0000, count=1 for 3 cycles -> microaddress 00,01,02,03.
REQ-038 microaddress=8'h12, bop=0001, opcode=4'h5 -> next microaddress 8'h50; dispatch=1 for exactly one cycle.
REQ-039 bop=0010 TGT=8'h40 with zero=1 -> 8'h40; same with zero=0 at 8'h20 -> 8'h21.
REQ-040 CALL at 8'h30 to 8'h80, then RET at 8'h85 -> 8'h80 then 8'h31; five nested CALLs (depth 4) then five RETs -> stack_err=1 and final next 8'h00.
REQ-041 HALT at 8'h07 -> halted=1, microaddress 8'h08 held for 10 cycles; go=1 -> RUN resumes from 8'h08.
REQ-042 rst_n pulsed low mid-RUN at 8'hFF with count=1 -> microaddress 8'h00 asynchronously, state IDLE; separately, a CONT at 8'hFF wraps to 8'h00.

Source files
------------

// File: rtl/sequencer_pkg.sv
// Shared microcode definitions: sequencer states, branch-operation encodings
// and the address increment helper used by the sequencer, control store and
// assembler tables.
package sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [3:0] BOP_CONT     = 4'h0;
    localparam logic [3:0] BOP_DISPATCH = 4'h1;
    localparam logic [3:0] BOP_JZ       = 4'h2;
    localparam logic [3:0] BOP_JNZ      = 4'h3;
    localparam logic [3:0] BOP_JC       = 4'h4;
    localparam logic [3:0] BOP_JNC      = 4'h5;
    localparam logic [3:0] BOP_JN       = 4'h6;
    localparam logic [3:0] BOP_JV       = 4'h7;
    localparam logic [3:0] BOP_CALL     = 4'h8;
    localparam logic [3:0] BOP_RET      = 4'h9;
    localparam logic [3:0] BOP_HALT     = 4'hA;

    // Sequential successor of a microaddress; wraps 8'hFF to 8'h00.
    function automatic logic [7:0] addr_inc(input logic [7:0] a);
        return a + 8'd1;
    endfunction

endpackage

// File: rtl/micro_stack.sv
// Return-address stack for micro-subroutine calls. Entry 0 is the top; a
// push onto a full stack shifts the oldest entry out of the bottom.
module micro_stack #(
    parameter int STACK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int CW = $clog2(STACK_DEPTH + 1);

    logic [7:0]    entry_q [STACK_DEPTH];
    logic [CW-1:0] count_q;

    assign dout  = entry_q[0];
    assign full  = (count_q == CW'(STACK_DEPTH));
    assign empty = (count_q == '0);

    // Shift entries down on push, up on pop; occupancy saturates at depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) entry_q[i] <= 8'h00;
        end else if (push) begin
            entry_q[0] <= din;
            for (int i = 1; i < STACK_DEPTH; i++) entry_q[i] <= entry_q[i-1];
            if (!full) count_q <= count_q + CW'(1);
        end else if (pop && !empty) begin
            for (int i = 0; i < STACK_DEPTH - 1; i++) entry_q[i] <= entry_q[i+1];
            entry_q[STACK_DEPTH-1] <= 8'h00;
            count_q <= count_q - CW'(1);
        end
    end

endmodule

// File: rtl/sequencer.sv
// Microprogram sequencer: computes the next control-store address from the
// current microword's branch fields, ALU flags and a return-address stack.
// dispatch is combinational and valid in the cycle the DISPATCH microword
// is presented; microaddress changes on the following edge.
module sequencer
    import sequencer_pkg::*;
#(
    parameter int STACK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic [3:0] opcode,
    input  logic [3:0] bop,
    input  logic       count,
    input  logic [3:0] micro_ad_high,
    input  logic [3:0] micro_ad_low,
    input  logic       zero,
    input  logic       carry,
    input  logic       negative,
    input  logic       overflow,
    output logic [7:0] microaddress,
    output logic       dispatch,
    output logic       halted,
    output logic       stack_err,
    output state_t     dbg_state
);

    state_t     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic       err_q, err_d;
    logic       push, pop, stk_full, stk_empty;
    logic [7:0] stk_dout, tgt, inc;

    assign tgt          = {micro_ad_high, micro_ad_low};
    assign inc          = addr_inc(addr_q);
    assign microaddress = addr_q;
    assign halted       = (state_q == ST_HALT);
    assign stack_err    = err_q;
    assign dbg_state    = state_q;

    micro_stack #(.STACK_DEPTH(STACK_DEPTH)) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (inc),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // Next-address, next-state and stack control selection.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        err_d    = err_q;
        push     = 1'b0;
        pop      = 1'b0;
        dispatch = 1'b0;
        case (state_q)
            ST_IDLE: if (go) state_d = ST_RUN;
            ST_HALT: if (go) state_d = ST_RUN;
            ST_RUN: begin
                case (bop)
                    BOP_DISPATCH: begin
                        addr_d   = {opcode, 4'h0};
                        dispatch = 1'b1;
                    end
                    BOP_JZ:  addr_d = zero      ? tgt : inc;
                    BOP_JNZ: addr_d = !zero     ? tgt : inc;
                    BOP_JC:  addr_d = carry     ? tgt : inc;
                    BOP_JNC: addr_d = !carry    ? tgt : inc;
                    BOP_JN:  addr_d = negative  ? tgt : inc;
                    BOP_JV:  addr_d = overflow  ? tgt : inc;
                    BOP_CALL: begin
                        push   = 1'b1;
                        addr_d = tgt;
                        if (stk_full) err_d = 1'b1;
                    end
                    BOP_RET: begin
                        pop = 1'b1;
                        if (stk_empty) begin
                            addr_d = 8'h00;
                            err_d  = 1'b1;
                        end else begin
                            addr_d = stk_dout;
                        end
                    end
                    BOP_HALT: begin
                        addr_d  = inc;
                        state_d = ST_HALT;
                    end
                    default: addr_d = count ? inc : tgt;
                endcase
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer state, microaddress and sticky stack error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= 8'h00;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_sequencer.sv
// Bench for the microprogram sequencer: a queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed addresses.
module tb_sequencer;
    import sequencer_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       go = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic [3:0] bop = 4'h0;
    logic       count = 1'b0;
    logic [3:0] micro_ad_high = 4'h0;
    logic [3:0] micro_ad_low = 4'h0;
    logic       zero = 1'b0, carry = 1'b0, negative = 1'b0, overflow = 1'b0;
    logic [7:0] microaddress;
    logic       dispatch, halted, stack_err;
    state_t     dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic chk_en = 1'b0;
    logic last_disp;

    // model state
    state_t     m_mode = ST_IDLE;
    logic [7:0] m_addr = 8'h00;
    logic       m_err = 1'b0;
    logic [7:0] m_stk[$];
    logic [7:0] m_tgt, m_inc;
    logic       m_take;

    sequencer #(.STACK_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .go            (go),
        .opcode        (opcode),
        .bop           (bop),
        .count         (count),
        .micro_ad_high (micro_ad_high),
        .micro_ad_low  (micro_ad_low),
        .zero          (zero),
        .carry         (carry),
        .negative      (negative),
        .overflow      (overflow),
        .microaddress  (microaddress),
        .dispatch      (dispatch),
        .halted        (halted),
        .stack_err     (stack_err),
        .dbg_state     (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // reference model: stack is a bounded queue, newest at the back
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = ST_IDLE;
            m_addr = 8'h00;
            m_err  = 1'b0;
            m_stk.delete();
        end else begin
            m_tgt = {micro_ad_high, micro_ad_low};
            m_inc = 8'((int'(m_addr) + 1) % 256);
            if (m_mode == ST_IDLE || m_mode == ST_HALT) begin
                if (go) m_mode = ST_RUN;
            end else begin
                m_take = 1'b0;
                case (int'(bop))
                    2: m_take = zero;
                    3: m_take = !zero;
                    4: m_take = carry;
                    5: m_take = !carry;
                    6: m_take = negative;
                    7: m_take = overflow;
                    default: m_take = 1'b0;
                endcase
                if (bop == 4'd1) m_addr = {opcode, 4'h0};
                else if (bop >= 4'd2 && bop <= 4'd7) m_addr = m_take ? m_tgt : m_inc;
                else if (bop == 4'd8) begin
                    if (m_stk.size() == DEPTH) begin
                        void'(m_stk.pop_front());
                        m_err = 1'b1;
                    end
                    m_stk.push_back(m_inc);
                    m_addr = m_tgt;
                end else if (bop == 4'd9) begin
                    if (m_stk.size() == 0) begin
                        m_addr = 8'h00;
                        m_err  = 1'b1;
                    end else m_addr = m_stk.pop_back();
                end else if (bop == 4'd10) begin
                    m_addr = m_inc;
                    m_mode = ST_HALT;
                end else m_addr = count ? m_inc : m_tgt;
            end
        end
    end

    // per-cycle compare, just before the rising edge
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (chk_en) begin
                check("addr", microaddress, m_addr);
                check("halted", 8'(halted), 8'(m_mode == ST_HALT));
                check("stack_err", 8'(stack_err), 8'(m_err));
                check("dispatch", 8'(dispatch), 8'(m_mode == ST_RUN && bop == 4'd1));
                check("state", 8'(dbg_state), 8'(m_mode));
            end
        end
    end

    // driver: apply one microword for one clock, called at negedge+2
    task automatic cyc(input logic g, input logic [3:0] b, input logic c,
                       input logic [7:0] t, input logic [3:0] op, input logic [3:0] fl);
        go = g; bop = b; count = c;
        {micro_ad_high, micro_ad_low} = t;
        opcode = op;
        {zero, carry, negative, overflow} = fl;
        #1 last_disp = dispatch;
        @(negedge clk);
        #2;
    endtask

    task automatic jmp(input logic [7:0] t);
        cyc(1'b0, 4'h0, 1'b0, t, 4'h0, 4'h0);
    endtask

    task automatic inc_n(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 1'b1, 8'h00, 4'h0, 4'h0);
    endtask

    initial begin
        @(negedge clk);
        #2;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        check("rst_addr", microaddress, 8'h00);
        check("rst_state", 8'(dbg_state), 8'(ST_IDLE));
        check("rst_err", 8'(stack_err), 8'h00);

        // IDLE holds without go
        cyc(1'b0, 4'h0, 1'b1, 8'h00, 4'h0, 4'h0);
        check("idle_hold", 8'(dbg_state), 8'(ST_IDLE));

        // go then sequential 00,01,02,03
        cyc(1'b1, 4'h0, 1'b1, 8'h00, 4'h0, 4'h0);
        check("go_addr", microaddress, 8'h00);
        check("go_state", 8'(dbg_state), 8'(ST_RUN));
        inc_n(1); check("seq1", microaddress, 8'h01);
        inc_n(1); check("seq2", microaddress, 8'h02);
        cyc(1'b1, 4'h0, 1'b1, 8'h00, 4'h0, 4'hF);  // go and flags ignored in RUN
        check("seq3", microaddress, 8'h03);

        // dispatch from 12 with opcode 5
        jmp(8'h12);
        check("jmp12", microaddress, 8'h12);
        cyc(1'b0, 4'h1, 1'b0, 8'hAA, 4'h5, 4'hF);
        check("disp_addr", microaddress, 8'h50);
        check("disp_pulse", 8'(last_disp), 8'h01);
        inc_n(1);
        check("disp_drop", 8'(last_disp), 8'h00);

        // conditional branches
        cyc(1'b0, 4'h2, 1'b0, 8'h40, 4'h0, 4'b1000);
        check("jz_take", microaddress, 8'h40);
        jmp(8'h20);
        cyc(1'b0, 4'h2, 1'b0, 8'h40, 4'h0, 4'b0000);
        check("jz_fall", microaddress, 8'h21);
        cyc(1'b0, 4'h3, 1'b0, 8'h60, 4'h0, 4'b0000);
        check("jnz_take", microaddress, 8'h60);
        cyc(1'b0, 4'h4, 1'b0, 8'h70, 4'h0, 4'b0100);
        check("jc_take", microaddress, 8'h70);
        cyc(1'b0, 4'h5, 1'b0, 8'h10, 4'h0, 4'b0100);
        check("jnc_fall", microaddress, 8'h71);
        cyc(1'b0, 4'h6, 1'b0, 8'h33, 4'h0, 4'b0010);
        check("jn_take", microaddress, 8'h33);
        cyc(1'b0, 4'h7, 1'b0, 8'h55, 4'h0, 4'b1110);
        check("jv_fall", microaddress, 8'h34);
        cyc(1'b0, 4'hC, 1'b0, 8'h66, 4'h0, 4'h0);
        check("bopC_cont", microaddress, 8'h66);

        // call / return
        jmp(8'h30);
        cyc(1'b0, 4'h8, 1'b0, 8'h80, 4'h0, 4'h0);
        check("call", microaddress, 8'h80);
        inc_n(5);
        check("sub_body", microaddress, 8'h85);
        cyc(1'b0, 4'h9, 1'b0, 8'hEE, 4'h0, 4'hF);
        check("ret", microaddress, 8'h31);
        check("ret_noerr", 8'(stack_err), 8'h00);

        // five nested calls overflow a depth-4 stack
        cyc(1'b0, 4'h8, 1'b0, 8'hA0, 4'h0, 4'h0);
        cyc(1'b0, 4'h8, 1'b0, 8'hB0, 4'h0, 4'h0);
        cyc(1'b0, 4'h8, 1'b0, 8'hC0, 4'h0, 4'h0);
        cyc(1'b0, 4'h8, 1'b0, 8'hD0, 4'h0, 4'h0);
        check("nest4_err", 8'(stack_err), 8'h00);
        cyc(1'b0, 4'h8, 1'b0, 8'hE0, 4'h0, 4'h0);
        check("nest5_err", 8'(stack_err), 8'h01);
        cyc(1'b0, 4'h9, 1'b0, 8'h00, 4'h0, 4'h0); check("ret1", microaddress, 8'hD1);
        cyc(1'b0, 4'h9, 1'b0, 8'h00, 4'h0, 4'h0); check("ret2", microaddress, 8'hC1);
        cyc(1'b0, 4'h9, 1'b0, 8'h00, 4'h0, 4'h0); check("ret3", microaddress, 8'hB1);
        cyc(1'b0, 4'h9, 1'b0, 8'h00, 4'h0, 4'h0); check("ret4", microaddress, 8'hA1);
        cyc(1'b0, 4'h9, 1'b0, 8'h55, 4'h0, 4'h0);
        check("ret_empty", microaddress, 8'h00);
        check("ret_err", 8'(stack_err), 8'h01);

        // halt and resume
        jmp(8'h07);
        cyc(1'b0, 4'hA, 1'b0, 8'h99, 4'h0, 4'h0);
        check("halt_addr", microaddress, 8'h08);
        check("halted", 8'(halted), 8'h01);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 255)), 4'h3, 4'($urandom_range(0, 15)));
            check("halt_hold", microaddress, 8'h08);
        end
        cyc(1'b1, 4'h0, 1'b1, 8'h00, 4'h0, 4'h0);
        check("resume_addr", microaddress, 8'h08);
        check("resume_run", 8'(dbg_state), 8'(ST_RUN));
        inc_n(1);
        check("resume_seq", microaddress, 8'h09);

        // wrap at FF
        jmp(8'hFF);
        inc_n(1);
        check("wrap", microaddress, 8'h00);

        // async reset mid-RUN at FF
        jmp(8'hFF);
        go = 1'b0; bop = 4'h0; count = 1'b1;
        rst_n = 1'b0;
        #1;
        check("arst_addr", microaddress, 8'h00);
        check("arst_state", 8'(dbg_state), 8'(ST_IDLE));
        check("arst_err", 8'(stack_err), 8'h00);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        inc_n(2);
        check("arst_idle", 8'(dbg_state), 8'(ST_IDLE));
        cyc(1'b1, 4'h0, 1'b1, 8'h00, 4'h0, 4'h0);
        check("arst_go", microaddress, 8'h00);

        // reset during a CALL clears the stack
        cyc(1'b0, 4'h8, 1'b0, 8'h44, 4'h0, 4'h0);
        bop = 4'h8; {micro_ad_high, micro_ad_low} = 8'h77;
        rst_n = 1'b0;
        #1;
        check("call_rst_addr", microaddress, 8'h00);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        cyc(1'b1, 4'h0, 1'b1, 8'h00, 4'h0, 4'h0);
        cyc(1'b0, 4'h9, 1'b0, 8'h00, 4'h0, 4'h0);
        check("stk_cleared", microaddress, 8'h00);
        check("stk_cleared_err", 8'(stack_err), 8'h01);

        inc_n(1);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
